// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x400@70), RGB332 field widths and sizing helpers.
package vga_pkg;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;
   localparam int VGA_V_ACTIVE = 400;
   localparam int VGA_V_FRONT  = 12;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 35;

   localparam int RGB_R_W = 3;
   localparam int RGB_G_W = 3;
   localparam int RGB_B_W = 2;
   localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

   function automatic int line_total(input int active, input int front, input int sync,
                                     input int back);
      return active + front + sync + back;
   endfunction

   // Width of a counter/coordinate covering 0..n-1, never below one bit.
   function automatic int coord_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/tick_div.sv
// Pixel-enable divider: counts 0..CLK_DIV-1 and asserts tick on the last count.
module tick_div
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int W = coord_width(CLK_DIV);

   logic [W-1:0] cnt;

   // With CLK_DIV=1 the counter sits at 0 forever, so tick is permanently high.
   assign tick = (cnt == W'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: h/v counters, sync decode, framebuffer read strobe and
// a one-tick output pipeline that keeps colour and syncs aligned.
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = VGA_H_ACTIVE,
   parameter int H_FRONT     = VGA_H_FRONT,
   parameter int H_SYNC      = VGA_H_SYNC,
   parameter int H_BACK      = VGA_H_BACK,
   parameter int V_ACTIVE    = VGA_V_ACTIVE,
   parameter int V_FRONT     = VGA_V_FRONT,
   parameter int V_SYNC      = VGA_V_SYNC,
   parameter int V_BACK      = VGA_V_BACK,
   parameter int CLK_DIV     = 2,
   parameter int SCALE_SHIFT = 1,
   parameter int RD_LAT      = 1,
   parameter bit HS_POL      = 1'b1,
   parameter bit VS_POL      = 1'b1
) (
   input  logic                                             clk,
   input  logic                                             rst,
   output logic                                             rd_en,
   output logic [coord_width(H_ACTIVE >> SCALE_SHIFT)-1:0]  rd_x,
   output logic [coord_width(V_ACTIVE >> SCALE_SHIFT)-1:0]  rd_y,
   input  logic [RGB_W-1:0]                                 pix_in,
   output logic [RGB_R_W-1:0]                               vga_r,
   output logic [RGB_G_W-1:0]                               vga_g,
   output logic [RGB_B_W-1:0]                               vga_b,
   output logic                                             hsync,
   output logic                                             vsync,
   output logic                                             frame_start,
   output logic                                             vblank
);
   localparam int H_TOTAL = line_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = line_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
   localparam int HC_W    = coord_width(H_TOTAL);
   localparam int VC_W    = coord_width(V_TOTAL);
   localparam int X_W     = coord_width(H_ACTIVE >> SCALE_SHIFT);
   localparam int Y_W     = coord_width(V_ACTIVE >> SCALE_SHIFT);

   // Read data must land before the tick that consumes it.
   if (CLK_DIV < 1 || CLK_DIV <= RD_LAT) begin : g_bad_cfg
      $error("vga_scan_ctrl: CLK_DIV must be >= 1 and greater than RD_LAT");
   end

   logic            tick;
   logic [HC_W-1:0] h_cnt, h_nxt;
   logic [VC_W-1:0] v_cnt, v_nxt;
   logic            h_wrap, v_wrap;
   logic            nxt_active, cur_active, in_hs, in_vs;
   logic            cap;
   logic [RGB_W-1:0] pix_reg, pix_src;

   tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   if (RD_LAT == 0) begin : g_lat0
      assign cap = rd_en;
   end else begin : g_latn
      logic [RD_LAT-1:0] rd_pipe;
      always_ff @(posedge clk) begin
         if (rst) rd_pipe <= '0;
         else     rd_pipe <= (rd_pipe << 1) | RD_LAT'(rd_en);
      end
      assign cap = rd_pipe[RD_LAT-1];
   end

   always_comb begin
      h_wrap     = (int'(h_cnt) == H_TOTAL - 1);
      v_wrap     = (int'(v_cnt) == V_TOTAL - 1);
      h_nxt      = h_wrap ? '0 : h_cnt + 1'b1;
      v_nxt      = v_cnt;
      if (h_wrap) v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
      nxt_active = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
      cur_active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
      in_hs      = (int'(h_cnt) >= H_ACTIVE + H_FRONT) &&
                   (int'(h_cnt) <  H_ACTIVE + H_FRONT + H_SYNC);
      in_vs      = (int'(v_cnt) >= V_ACTIVE + V_FRONT) &&
                   (int'(v_cnt) <  V_ACTIVE + V_FRONT + V_SYNC);
      // Data arriving on the tick clk itself bypasses the holding register.
      pix_src    = cap ? pix_in : pix_reg;
   end

   assign vblank = (int'(v_cnt) >= V_ACTIVE);

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt                 <= '0;
         v_cnt                 <= '0;
         rd_en                 <= 1'b0;
         rd_x                  <= '0;
         rd_y                  <= '0;
         frame_start           <= 1'b0;
         pix_reg               <= '0;
         {vga_r, vga_g, vga_b} <= '0;
         hsync                 <= ~HS_POL;
         vsync                 <= ~VS_POL;
      end else begin
         rd_en       <= 1'b0;
         rd_x        <= '0;
         rd_y        <= '0;
         frame_start <= 1'b0;
         if (cap) pix_reg <= pix_in;
         if (tick) begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            frame_start <= h_wrap && v_wrap;
            if (nxt_active) begin
               rd_en <= 1'b1;
               rd_x  <= X_W'(h_nxt >> SCALE_SHIFT);
               rd_y  <= Y_W'(v_nxt >> SCALE_SHIFT);
            end
            // Outputs present the pixel just left, one tick behind the counters.
            {vga_r, vga_g, vga_b} <= cur_active ? pix_src : '0;
            hsync <= in_hs ? HS_POL : ~HS_POL;
            vsync <= in_vs ? VS_POL : ~VS_POL;
         end
      end
   end
endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 400, visible lines per frame.
REQ-004 SHALL have parameters V_FRONT/V_SYNC/V_BACK, defaults 12/2/35, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel.
REQ-006 SHALL have parameter SCALE_SHIFT, default 1, framebuffer downscale (read coord = screen coord >> SCALE_SHIFT).
REQ-007 SHALL have parameter RD_LAT, default 1, clk cycles from rd_en to valid pix_in.
REQ-008 SHALL have parameters HS_POL/VS_POL, default 1/1, active level of hsync/vsync.
REQ-009 Clock and reset: one clock; reset is synchronous and active-high.
REQ-010 clk  in  1  system clock.
REQ-011 rst  in  1  synchronous active-high reset.
REQ-012 rd_en  out  1  one-clk framebuffer read strobe per active pixel.
REQ-013 rd_x  out  clog2(H_ACTIVE>>SCALE_SHIFT)  framebuffer column.
REQ-014 rd_y  out  clog2(V_ACTIVE>>SCALE_SHIFT)  framebuffer row.
REQ-015 pix_in  in  8  RGB332 pixel, valid RD_LAT clks after rd_en.
REQ-016 vga_r/vga_g/vga_b  out  3/3/2  colour outputs.
REQ-017 hsync, vsync  out  1 each  sync outputs.
REQ-018 frame_start  out  1  one-clk pulse at start of each frame.
REQ-019 vblank  out  1  high while v counter >= V_ACTIVE (game-update window).

Function
REQ-020 Pixel tick SHALL assert for one clk every CLK_DIV clks (divider counts 0..CLK_DIV-1, tick at CLK_DIV-1).
REQ-021 h_cnt SHALL advance on each tick, wrap from H_TOTAL-1 (sum of H params) to 0.
REQ-022 v_cnt SHALL increment (never decrement) when h_cnt wraps, wrap from V_TOTAL-1 to 0.
REQ-023 rd_en SHALL be registered, high for exactly the clk after a tick whose new (h_cnt,v_cnt) lies inside active area; low otherwise.
REQ-024 rd_x/rd_y SHALL equal h_cnt>>SCALE_SHIFT, v_cnt>>SCALE_SHIFT while rd_en high; 0 otherwise.
REQ-025 pix_in SHALL be captured exactly RD_LAT clks after rd_en into a colour register.
REQ-026 Output pipeline SHALL be one pixel tick: colour, hsync, vsync for pixel (h,v) SHALL all change together on the tick following (h,v).
REQ-027 Colour outputs SHALL be forced to 0 for blanked pixels, regardless of pix_in.
REQ-028 hsync SHALL equal HS_POL while H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC, else !HS_POL; vsync likewise with V params.
REQ-029 frame_start SHALL pulse for one clk on the tick where counters wrap (H_TOTAL-1,V_TOTAL-1)->(0,0).
REQ-030 Elaboration SHALL fail if CLK_DIV <= RD_LAT or CLK_DIV < 1.
REQ-031 With CLK_DIV=1 tick SHALL be permanently high and RD_LAT SHALL be 0.

Reset
REQ-032 On rst: divider, h_cnt, v_cnt = 0; rd_en=0; rd_x/rd_y=0; colours=0; hsync=!HS_POL; vsync=!VS_POL; frame_start=0; vblank=0.
REQ-033 rst mid-line/mid-frame SHALL take effect next clk; first tick after release SHALL be CLK_DIV clks later with counters (0,0).
REQ-034 In-flight read data arriving during or right after rst SHALL be discarded (colour stays 0).

Structure
REQ-035 Shared package vga_pkg SHALL hold 640x400@70 timing constants, RGB332 field widths, and total-count helper functions.
REQ-036 Pixel-enable divider SHALL be sub-module tick_div (param CLK_DIV, ports clk, rst, tick).
REQ-037 Counters, sync decode, read strobe and alignment pipeline SHALL be in vga_scan_ctrl.

Verification
REQ-038 Defaults, run 2 frames -> hsync period 1600 clks, low... high 192 clks; vsync period 449*1600 clks, active 2 lines; frame_start every 718400 clks.
REQ-039 Small params (H 8/2/2/2, V 4/1/1/1, CLK_DIV=2, SCALE_SHIFT=1) -> rd_x sequence 0,0,1,1,2,2,3,3 per line; 32 rd_en per frame.
REQ-040 Memory model returns pix_in=x^y after RD_LAT=1 -> vga colour matches model one tick later, zero in blanking even if pix_in=8'hFF.
REQ-041 HS_POL=0,VS_POL=0 -> syncs idle high, pulse low, same widths as REQ-038.
REQ-042 rst asserted at h=5,v=2 for 3 clks -> all outputs at reset values next clk; first tick CLK_DIV clks after release at (0,0); no stale colour.
REQ-043 CLK_DIV=1, RD_LAT=0 -> rd_en every active clk, counters advance every clk; CLK_DIV=2,RD_LAT=2 -> elaboration error.
